dsp_mac_pipe: RTL and testbench

- Parametrised successor to the fixed 18x18 DSP48A1 slice model: pre-adder, signed multiplier and post-adder/accumulator with configurable operand widths and pipeline depth.
- Adds valid tracking, per-sample OPMODE carried with its data, optional saturation, and pattern detection.
- Used as the arithmetic core of filter and MAC datapaths; cascades through PCIN/PCOUT.

---
 rtl/dsp_mac_pipe_if.sv | 33 +++
 rtl/dsp_mac_pipe.sv | 171 +++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - operand/result bundle for the pipelined DSP MAC
interface dsp_mac_pipe_if #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int P_WIDTH = 48
);
    logic                       CE;
    logic                       IN_VALID;
    logic [A_WIDTH-1:0]         A;
    logic [B_WIDTH-1:0]         B;
    logic [B_WIDTH-1:0]         D;
    logic [P_WIDTH-1:0]         C;
    logic [P_WIDTH-1:0]         PCIN;
    logic [7:0]                 OPMODE;
    logic                       OUT_VALID;
    logic [B_WIDTH-1:0]         BCOUT;
    logic [A_WIDTH+B_WIDTH-1:0] M;
    logic [P_WIDTH-1:0]         P;
    logic [P_WIDTH-1:0]         PCOUT;
    logic                       CARRYOUT;
    logic                       OVERFLOW;
    logic                       PATTERNDETECT;

    modport master (
        output CE, IN_VALID, A, B, D, C, PCIN, OPMODE,
        input  OUT_VALID, BCOUT, M, P, PCOUT, CARRYOUT, OVERFLOW, PATTERNDETECT
    );

    modport slave (
        input  CE, IN_VALID, A, B, D, C, PCIN, OPMODE,
        output OUT_VALID, BCOUT, M, P, PCOUT, CARRYOUT, OVERFLOW, PATTERNDETECT
    );
endinterface

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - pre-adder, signed multiplier and post-adder/accumulator pipeline
module dsp_mac_pipe #(
    parameter int               A_WIDTH  = 18,
    parameter int               B_WIDTH  = 18,
    parameter int               P_WIDTH  = 48,
    parameter int               AREG     = 1,
    parameter int               MREG     = 1,
    parameter int               PREG     = 1,
    parameter int               SATURATE = 0,
    parameter logic [P_WIDTH-1:0] PATTERN = '0
) (
    input logic           CLK,
    input logic           RST,
    dsp_mac_pipe_if.slave bus
);
    localparam int M_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int DAB_WIDTH = 2 * B_WIDTH + A_WIDTH;
    localparam int XD_WIDTH  = (DAB_WIDTH < P_WIDTH) ? DAB_WIDTH : P_WIDTH;

    // Stage 1 view of the sample
    logic signed [A_WIDTH-1:0] a1;
    logic signed [B_WIDTH-1:0] b1, d1;
    logic [P_WIDTH-1:0]        c1, pcin1;
    logic [7:0]                op1;
    logic                      v1;

    generate
        if (AREG != 0) begin : g_s1_reg
            logic signed [A_WIDTH-1:0] a_q;
            logic signed [B_WIDTH-1:0] b_q, d_q;
            logic [P_WIDTH-1:0]        c_q, pcin_q;
            logic [7:0]                op_q;
            logic                      v_q;
            // Stage 1: capture operands, mode and valid together
            always_ff @(posedge CLK) begin
                if (RST) begin
                    a_q <= '0; b_q <= '0; d_q <= '0; c_q <= '0;
                    pcin_q <= '0; op_q <= '0; v_q <= 1'b0;
                end else if (bus.CE) begin
                    a_q <= bus.A; b_q <= bus.B; d_q <= bus.D; c_q <= bus.C;
                    pcin_q <= bus.PCIN; op_q <= bus.OPMODE; v_q <= bus.IN_VALID;
                end
            end
            assign a1 = a_q; assign b1 = b_q; assign d1 = d_q; assign c1 = c_q;
            assign pcin1 = pcin_q; assign op1 = op_q; assign v1 = v_q;
        end else begin : g_s1_wire
            assign a1 = bus.A; assign b1 = bus.B; assign d1 = bus.D; assign c1 = bus.C;
            assign pcin1 = bus.PCIN; assign op1 = bus.OPMODE; assign v1 = bus.IN_VALID;
        end
    endgenerate

    // Pre-adder wraps at B_WIDTH; its output optionally replaces B at the multiplier
    logic signed [B_WIDTH-1:0] pre_sum, bcout;
    logic signed [M_WIDTH-1:0] prod;
    logic [XD_WIDTH-1:0]       xd1;
    logic [5:0]                opm1;

    assign pre_sum = op1[6] ? (d1 - b1) : (d1 + b1);
    assign bcout   = op1[4] ? pre_sum : b1;
    assign prod    = $signed({{B_WIDTH{a1[A_WIDTH-1]}}, a1}) *
                     $signed({{A_WIDTH{bcout[B_WIDTH-1]}}, bcout});
    assign xd1     = XD_WIDTH'({d1, a1, b1});
    // Only the post-adder mode bits travel further: {sub, cin, z[1:0], x[1:0]}
    assign opm1    = {op1[7], op1[5], op1[3:0]};

    // Stage M view of the sample
    logic signed [M_WIDTH-1:0] m2;
    logic [P_WIDTH-1:0]        c2, pcin2;
    logic [XD_WIDTH-1:0]       xd2;
    logic [5:0]                opm2;
    logic                      v2;

    generate
        if (MREG != 0) begin : g_m_reg
            logic signed [M_WIDTH-1:0] m_q;
            logic [P_WIDTH-1:0]        c_q, pcin_q;
            logic [XD_WIDTH-1:0]       xd_q;
            logic [5:0]                opm_q;
            logic                      v_q;
            // Stage M: register the product alongside the rest of its sample
            always_ff @(posedge CLK) begin
                if (RST) begin
                    m_q <= '0; c_q <= '0; pcin_q <= '0; xd_q <= '0;
                    opm_q <= '0; v_q <= 1'b0;
                end else if (bus.CE) begin
                    m_q <= prod; c_q <= c1; pcin_q <= pcin1; xd_q <= xd1;
                    opm_q <= opm1; v_q <= v1;
                end
            end
            assign m2 = m_q; assign c2 = c_q; assign pcin2 = pcin_q;
            assign xd2 = xd_q; assign opm2 = opm_q; assign v2 = v_q;
        end else begin : g_m_wire
            assign m2 = prod; assign c2 = c1; assign pcin2 = pcin1;
            assign xd2 = xd1; assign opm2 = opm1; assign v2 = v1;
        end
    endgenerate

    // Post-adder operands, sum and flags
    logic [P_WIDTH-1:0] pfb, x_mux, z_mux, p_d;
    logic [P_WIDTH:0]   x_cin, sum_d;
    logic               ovf_d, sub;

    assign sub = opm2[5];

    // X/Z operand select, P_WIDTH+1 bit add/subtract, overflow and clamp
    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (opm2[1:0])
            2'd1:    x_mux = {{(P_WIDTH-M_WIDTH){m2[M_WIDTH-1]}}, m2};
            2'd2:    x_mux = pfb;
            2'd3:    x_mux = P_WIDTH'(xd2);
            default: x_mux = '0;
        endcase
        case (opm2[3:2])
            2'd1:    z_mux = pcin2;
            2'd2:    z_mux = pfb;
            2'd3:    z_mux = c2;
            default: z_mux = '0;
        endcase
        x_cin = {1'b0, x_mux} + {{P_WIDTH{1'b0}}, opm2[4]};
        sum_d = sub ? ({1'b0, z_mux} - x_cin) : ({1'b0, z_mux} + x_cin);
        ovf_d = ((x_mux[P_WIDTH-1] ^ sub) == z_mux[P_WIDTH-1]) &&
                (sum_d[P_WIDTH-1] != z_mux[P_WIDTH-1]);
        p_d   = sum_d[P_WIDTH-1:0];
        if ((SATURATE != 0) && ovf_d) begin
            p_d = z_mux[P_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                   : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end

    generate
        if (PREG != 0) begin : g_p_reg
            logic [P_WIDTH-1:0] p_q;
            logic               co_q, ovf_q, pd_q, vo_q;
            // Stage P: result only moves on a valid sample so feedback sees the last result
            always_ff @(posedge CLK) begin
                if (RST) begin
                    p_q <= '0; co_q <= 1'b0; ovf_q <= 1'b0;
                    pd_q <= (PATTERN == '0); vo_q <= 1'b0;
                end else if (bus.CE) begin
                    vo_q <= v2;
                    if (v2) begin
                        p_q   <= p_d;
                        co_q  <= sum_d[P_WIDTH];
                        ovf_q <= ovf_d;
                        pd_q  <= (p_d == PATTERN);
                    end
                end
            end
            assign pfb               = p_q;
            assign bus.P             = p_q;
            assign bus.PCOUT         = p_q;
            assign bus.CARRYOUT      = co_q;
            assign bus.OVERFLOW      = ovf_q;
            assign bus.PATTERNDETECT = pd_q;
            assign bus.OUT_VALID     = vo_q;
        end else begin : g_p_wire
            assign pfb               = '0;
            assign bus.P             = p_d;
            assign bus.PCOUT         = p_d;
            assign bus.CARRYOUT      = sum_d[P_WIDTH];
            assign bus.OVERFLOW      = ovf_d;
            assign bus.PATTERNDETECT = (p_d == PATTERN);
            assign bus.OUT_VALID     = v2;
        end
    endgenerate

    assign bus.BCOUT = bcout;
    assign bus.M     = m2;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - directed vector bench for dsp_mac_pipe
module tb_dsp_mac_pipe;
    logic        clk;
    logic        rst;
    logic        ce, in_valid;
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic [7:0]  opmode;
    int          checks;
    int          failures;

    typedef struct {
        logic [7:0]  op;
        logic [17:0] a, b, d;
        logic [47:0] c, pcin;
        logic [17:0] bc;
        logic [35:0] m;
        logic [47:0] p, psat;
        logic        co, ovf;
    } vec_t;

    vec_t vecs[9];

    dsp_mac_pipe_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) if_a ();
    dsp_mac_pipe_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) if_s ();
    dsp_mac_pipe_if #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48)) if_w ();

    assign if_a.CE = ce; assign if_a.IN_VALID = in_valid; assign if_a.A = a; assign if_a.B = b;
    assign if_a.D = d; assign if_a.C = c; assign if_a.PCIN = pcin; assign if_a.OPMODE = opmode;
    assign if_s.CE = ce; assign if_s.IN_VALID = in_valid; assign if_s.A = a; assign if_s.B = b;
    assign if_s.D = d; assign if_s.C = c; assign if_s.PCIN = pcin; assign if_s.OPMODE = opmode;
    assign if_w.CE = ce; assign if_w.IN_VALID = in_valid; assign if_w.A = a; assign if_w.B = b;
    assign if_w.D = d; assign if_w.C = c; assign if_w.PCIN = pcin; assign if_w.OPMODE = opmode;

    dsp_mac_pipe #(.AREG(1), .MREG(1), .PREG(1), .SATURATE(0), .PATTERN(48'd37))
        u_a (.CLK(clk), .RST(rst), .bus(if_a));
    dsp_mac_pipe #(.AREG(1), .MREG(1), .PREG(1), .SATURATE(1), .PATTERN(48'd0))
        u_s (.CLK(clk), .RST(rst), .bus(if_s));
    dsp_mac_pipe #(.AREG(0), .MREG(0), .PREG(1), .SATURATE(0), .PATTERN(48'd0))
        u_w (.CLK(clk), .RST(rst), .bus(if_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [17:0] av, input logic [17:0] bv,
                         input logic [17:0] dv, input logic [47:0] cv, input logic [47:0] pv,
                         input logic v);
        opmode = op; a = av; b = bv; d = dv; c = cv; pcin = pv; in_valid = v;
    endtask

    task automatic idle();
        drive(8'h00, 18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b0);
    endtask

    int exp_st_p[9] = '{0, 0, 5, 10, 10, 10, 15, 20, 20};
    int exp_st_v[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        logic seen;
        int   mix_p[3];
        checks = 0;
        failures = 0;
        //             op     a              b              d       c                    pcin        bc              m             p                    psat                 co    ovf
        vecs[0] = '{8'h1D, 18'd3,         18'd4,         18'd5,  48'd10,              48'd0,      18'd9,          36'd27,       48'd37,              48'd37,              1'b0, 1'b0};
        vecs[1] = '{8'hDD, 18'd2,         18'd3,         18'd10, 48'd100,             48'd0,      18'd7,          36'd14,       48'd86,              48'd86,              1'b0, 1'b0};
        vecs[2] = '{8'h0D, 18'(-3),       18'd7,         18'd0,  48'd5,               48'd0,      18'd7,          36'(-21),     48'hFFFF_FFFF_FFF0,  48'hFFFF_FFFF_FFF0,  1'b0, 1'b0};
        vecs[3] = '{8'h0D, 18'(-1),       18'd1,         18'd0,  48'd1,               48'd0,      18'd1,          36'(-1),      48'd0,               48'd0,               1'b1, 1'b0};
        vecs[4] = '{8'h7D, 18'd4,         18'd5,         18'd2,  48'd20,              48'd0,      18'(-3),        36'(-12),     48'd9,               48'd9,               1'b1, 1'b0};
        vecs[5] = '{8'h03, 18'd1,         18'd2,         18'd1,  48'd0,               48'd0,      18'd2,          36'd2,        48'h10_0004_0002,    48'h10_0004_0002,    1'b0, 1'b0};
        vecs[6] = '{8'h04, 18'd0,         18'd0,         18'd0,  48'd0,               48'h1234,   18'd0,          36'd0,        48'h1234,            48'h1234,            1'b0, 1'b0};
        vecs[7] = '{8'h0D, 18'd1,         18'd1,         18'd0,  48'h7FFF_FFFF_FFFF,  48'd0,      18'd1,          36'd1,        48'h8000_0000_0000,  48'h7FFF_FFFF_FFFF,  1'b0, 1'b1};
        vecs[8] = '{8'h8D, 18'd1,         18'd1,         18'd0,  48'h8000_0000_0000,  48'd0,      18'd1,          36'd1,        48'h7FFF_FFFF_FFFF,  48'h8000_0000_0000,  1'b0, 1'b1};

        rst = 1'b1; ce = 1'b1; idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(if_a.OUT_VALID), 64'd0);
        chk("rst_p", 64'(if_a.P), 64'd0);
        chk("rst_pcout", 64'(if_a.PCOUT), 64'd0);
        chk("rst_m", 64'(if_a.M), 64'd0);
        chk("rst_bcout", 64'(if_a.BCOUT), 64'd0);
        chk("rst_carryout", 64'(if_a.CARRYOUT), 64'd0);
        chk("rst_overflow", 64'(if_a.OVERFLOW), 64'd0);
        chk("rst_patdet_pat37", 64'(if_a.PATTERNDETECT), 64'd0);
        chk("rst_patdet_pat0", 64'(if_s.PATTERNDETECT), 64'd1);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, vecs[i].pcin, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_bcout", i), 64'(if_a.BCOUT), 64'(vecs[i].bc));
            chk($sformatf("v%0d_early_valid1", i), 64'(if_a.OUT_VALID), 64'd0);
            chk($sformatf("v%0d_lat1_valid", i), 64'(if_w.OUT_VALID), 64'd1);
            chk($sformatf("v%0d_lat1_p", i), 64'(if_w.P), 64'(vecs[i].p));
            @(negedge clk) idle();
            @(posedge clk); #1;
            chk($sformatf("v%0d_m", i), 64'(if_a.M), 64'(vecs[i].m));
            chk($sformatf("v%0d_early_valid2", i), 64'(if_a.OUT_VALID), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 64'(if_a.OUT_VALID), 64'd1);
            chk($sformatf("v%0d_p", i), 64'(if_a.P), 64'(vecs[i].p));
            chk($sformatf("v%0d_pcout", i), 64'(if_a.PCOUT), 64'(vecs[i].p));
            chk($sformatf("v%0d_carryout", i), 64'(if_a.CARRYOUT), 64'(vecs[i].co));
            chk($sformatf("v%0d_overflow", i), 64'(if_a.OVERFLOW), 64'(vecs[i].ovf));
            chk($sformatf("v%0d_patdet", i), 64'(if_a.PATTERNDETECT), 64'(vecs[i].p == 48'd37));
            chk($sformatf("v%0d_sat_p", i), 64'(if_s.P), 64'(vecs[i].psat));
            chk($sformatf("v%0d_sat_overflow", i), 64'(if_s.OVERFLOW), 64'(vecs[i].ovf));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_pulse", i), 64'(if_a.OUT_VALID), 64'd0);
            chk($sformatf("v%0d_p_held", i), 64'(if_a.P), 64'(vecs[i].p));
        end

        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4) drive(8'h09, 18'd1, 18'd5, 18'd0, 48'd0, 48'd0, 1'b1);
            else idle();
            @(posedge clk); #1;
            if (i >= 2 && i <= 5) begin
                chk($sformatf("acc%0d_valid", i - 2), 64'(if_a.OUT_VALID), 64'd1);
                chk($sformatf("acc%0d_p", i - 2), 64'(if_a.P), 64'(5 * (i - 1)));
            end
            if (i == 6) chk("acc_done_valid", 64'(if_a.OUT_VALID), 64'd0);
        end

        mix_p = '{22, 101, 104};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            case (i)
                0:       drive(8'h09, 18'd1, 18'd2, 18'd0, 48'd0,   48'd0, 1'b1);
                1:       drive(8'h0D, 18'd1, 18'd1, 18'd0, 48'd100, 48'd0, 1'b1);
                2:       drive(8'h09, 18'd1, 18'd3, 18'd0, 48'd0,   48'd0, 1'b1);
                default: idle();
            endcase
            @(posedge clk); #1;
            if (i >= 2) chk($sformatf("mix%0d_p", i - 2), 64'(if_a.P), 64'(mix_p[i - 2]));
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk) drive(8'h0D, 18'd1, 18'd1, 18'd0, 48'd7, 48'd0, 1'b1);
            @(posedge clk);
        end
        @(negedge clk); rst = 1'b1; idle();
        @(posedge clk); #1;
        chk("midrst_valid", 64'(if_a.OUT_VALID), 64'd0);
        chk("midrst_p", 64'(if_a.P), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (if_a.OUT_VALID) seen = 1'b1;
        end
        chk("midrst_no_stale_valid", 64'(seen), 64'd0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ce = !(i == 4 || i == 5);
            if (i < 4) drive(8'h09, 18'd1, 18'd5, 18'd0, 48'd0, 48'd0, 1'b1);
            else idle();
            @(posedge clk); #1;
            chk($sformatf("stall%0d_valid", i), 64'(if_a.OUT_VALID), 64'(exp_st_v[i]));
            chk($sformatf("stall%0d_p", i), 64'(if_a.P), 64'(exp_st_p[i]));
        end
        @(negedge clk) ce = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
